mux_select_arbiter: RTL and testbench
=====================================

// Module: mux_select_arbiter
// PURPOSE
//  Shares one twoInputMultiplexer between two requesters. Each requester raises req, waits for gnt,
//  then owns the mux while its req stays high. The arbiter drives the mux select (address0).
//  Priority is round-robin, and a hold limit stops either requester from starving the other.
//  The block sits in front of the mux in the datapath; out/out_valid feed the downstream consumer.
// PARAMETERS
//  WIDTH     1  data width of in0/in1/out (bitwise mux per bit)
//  MAX_HOLD  4  max consecutive grant cycles while the other side waits; legal range 1..(2**CNT_W)-1
//  CNT_W     4  width of the internal hold counter
// PORTS
//  clk        in   1      system clock; all state updates on the rising edge
//  reset      in   1      synchronous, active-high reset
//  req0       in   1      requester 0 wants the mux; held high for the whole transfer
//  req1       in   1      requester 1 wants the mux
//  in0        in   WIDTH  requester 0 data, mux input 0
//  in1        in   WIDTH  requester 1 data, mux input 1
//  gnt0       out  1      registered; requester 0 owns the mux this cycle
//  gnt1       out  1      registered; requester 1 owns the mux this cycle
//  sel        out  1      registered mux select (address0): 0 = in0, 1 = in1
//  out        out  WIDTH  mux output; sel ? in1 : in0, combinational from sel and data
//  out_valid  out  1      gnt0 | gnt1
// BEHAVIOUR
//  Reset (reset=1 at posedge) forces state IDLE, gnt0=gnt1=0, sel=0, out_valid=0, cnt=0, last=1.
//  - last=1 makes requester 0 win the first tie.
//  - Reset wins over any request, and applies mid-grant too.
//  States: IDLE, GRANT0, GRANT1. gnt0 is 1 only in GRANT0; gnt1 is 1 only in GRANT1. Never both 1.
//  Latency: a req seen at edge N gives gnt at edge N+1. There is no combinational req->gnt path.
//  IDLE:
//  - req0 & req1: go to GRANT(~last).
//  - Only reqX: go to GRANTX.
//  - Neither: stay IDLE.
//  GRANTX (other = Y):
//  - Entry: cnt <= 0, last <= X, sel <= X.
//  - Stay while reqX=1 and !(reqY=1 && cnt == MAX_HOLD-1). cnt increments each stay cycle,
//    saturating at 2**CNT_W-1.
//  - reqX=0 and reqY=1: go straight to GRANTY next edge, with no idle bubble.
//  - reqX=0 and reqY=0: go to IDLE.
//  - reqX=1, reqY=1 and cnt == MAX_HOLD-1: preempt and go to GRANTY. X re-queues and is served
//    after Y under the same rules.
//  Preemption:
//  - cnt only limits the holder while the other side is requesting.
//  - With reqY=0, X may hold indefinitely.
//  - MAX_HOLD=1 with both requesting: the grant alternates every cycle.
//  IDLE keeps the last sel value so out does not glitch between grants. out is don't-care while out_valid=0.
//  Sample out only when out_valid=1. out settles within the mux gate delay after a sel or in change,
//  and consumers sample on the next posedge.
//  reqX dropping during GRANTX is legal at any cycle, and the grant ends at the next edge.
//  A gnt high at edge N means the mux carries that requester's data for the whole cycle N..N+1.
// TESTING
//  1 Reset: hold reset 2 cycles with req0=req1=1 -> gnt0=gnt1=0, sel=0, out_valid=0. First edge after
//    release: gnt0=1.
//  2 Single requester: req1=1 for 3 cycles, in1=1, in0=0 -> gnt1=1 and sel=1 one cycle after req1,
//    for 3 cycles, out=1. After req1 drops: IDLE, out_valid=0.
//  3 Tie round-robin: req0=req1=1, each dropping its req after 2 grant cycles -> grant order
//    0,0,1,1,0,0,... and gnt0&gnt1 never 1.
//  4 Preemption, MAX_HOLD=4: req0 held high, then req1 raised -> gnt0 lasts exactly 4 cycles, then gnt1.
//    With req1 low instead, gnt0 stays high for 20+ cycles.
//  5 Back-to-back handoff: in GRANT0, req0 falls at the same edge req1 is high -> gnt1=1 next edge,
//    with no IDLE cycle.
//  6 Reset mid-grant: assert reset during GRANT1 with cnt=2 -> next edge gnt1=0, sel=0.
//    After release with both requesting, gnt0 wins.

Source files
------------

// File: rtl/mux_select_arbiter_if.sv
// Bus between two requesters and the arbiter that owns the shared two-input mux.
interface mux_select_arbiter_if #(
  parameter int WIDTH = 1
);
  logic             req0;
  logic             req1;
  logic [WIDTH-1:0] in0;
  logic [WIDTH-1:0] in1;
  logic             gnt0;
  logic             gnt1;
  logic             sel;
  logic [WIDTH-1:0] out;
  logic             out_valid;

  modport master (
    output req0, req1, in0, in1,
    input  gnt0, gnt1, sel, out, out_valid
  );

  modport slave (
    input  req0, req1, in0, in1,
    output gnt0, gnt1, sel, out, out_valid
  );
endinterface

// File: rtl/mux_select_arbiter.sv
// Round-robin arbiter with a hold limit that drives the select of a shared two-input mux.
module mux_select_arbiter #(
  parameter int WIDTH    = 1,
  parameter int MAX_HOLD = 4,
  parameter int CNT_W    = 4
) (
  input logic                clk,
  input logic                reset,
  mux_select_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             last;
  logic             sel_r;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  // At-or-past the limit, so a rival arriving after a long solo hold still preempts at once.
  function automatic logic at_limit(input logic [CNT_W-1:0] v);
    return int'(v) >= MAX_HOLD - 1;
  endfunction

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.req0 && bus.req1) state_nxt = last ? GRANT0 : GRANT1;
        else if (bus.req0)        state_nxt = GRANT0;
        else if (bus.req1)        state_nxt = GRANT1;
      end
      GRANT0: begin
        if (!bus.req0)                       state_nxt = bus.req1 ? GRANT1 : IDLE;
        else if (bus.req1 && at_limit(cnt))  state_nxt = GRANT1;
      end
      GRANT1: begin
        if (!bus.req1)                       state_nxt = bus.req0 ? GRANT0 : IDLE;
        else if (bus.req0 && at_limit(cnt))  state_nxt = GRANT0;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      last  <= 1'b1;
      sel_r <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state && state_nxt == GRANT0) begin
        cnt   <= '0;
        last  <= 1'b0;
        sel_r <= 1'b0;
      end else if (state_nxt != state && state_nxt == GRANT1) begin
        cnt   <= '0;
        last  <= 1'b1;
        sel_r <= 1'b1;
      end else if (state_nxt != IDLE) begin
        cnt <= sat_inc(cnt);
      end
    end
  end

  // Select is held through IDLE so the mux output does not move between grants.
  assign bus.gnt0      = (state == GRANT0);
  assign bus.gnt1      = (state == GRANT1);
  assign bus.sel       = sel_r;
  assign bus.out_valid = (state != IDLE);
  assign bus.out       = sel_r ? bus.in1 : bus.in0;

endmodule

// File: tb/tb_mux_select_arbiter.sv
// Directed bench for mux_select_arbiter: a MAX_HOLD=4 instance plus a MAX_HOLD=1 instance on the same requests.
module tb_mux_select_arbiter;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  mux_select_arbiter_if #(.WIDTH(1)) bus ();
  mux_select_arbiter_if #(.WIDTH(1)) bus1 ();

  mux_select_arbiter #(.WIDTH(1), .MAX_HOLD(4), .CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  mux_select_arbiter #(.WIDTH(1), .MAX_HOLD(1), .CNT_W(4)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1.slave)
  );

  assign bus1.req0 = bus.req0;
  assign bus1.req1 = bus.req1;
  assign bus1.in0  = bus.in0;
  assign bus1.in1  = bus.in1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [1:0] rq_tab [6];
  logic       g1_tab [6];

  initial begin
    total = 0;
    bad   = 0;
    rq_tab = '{2'b11, 2'b11, 2'b10, 2'b11, 2'b01, 2'b11};
    g1_tab = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    // 1: reset held two edges with both requesting
    reset = 1'b1;
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    bus.in0  = 1'b0;
    bus.in1  = 1'b0;
    tick();
    tick();
    chk("rst_gnt0", bus.gnt0, 1'b0);
    chk("rst_gnt1", bus.gnt1, 1'b0);
    chk("rst_sel", bus.sel, 1'b0);
    chk("rst_vld", bus.out_valid, 1'b0);
    reset = 1'b0;
    tick();
    chk("rel_gnt0", bus.gnt0, 1'b1);
    chk("rel_gnt1", bus.gnt1, 1'b0);
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    tick();
    chk("rel_idle", bus.out_valid, 1'b0);

    // 2: single requester 1 for three edges
    bus.in1  = 1'b1;
    bus.in0  = 1'b0;
    bus.req1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("single_gnt1", bus.gnt1, 1'b1);
      chk("single_sel", bus.sel, 1'b1);
      chk("single_out", bus.out, 1'b1);
    end
    bus.req1 = 1'b0;
    tick();
    chk("single_idle_vld", bus.out_valid, 1'b0);
    chk("single_idle_gnt1", bus.gnt1, 1'b0);
    chk("single_idle_sel", bus.sel, 1'b1);

    // 3: tie round-robin, each side drops req after two grant cycles
    for (int i = 0; i < 6; i++) begin
      bus.req1 = rq_tab[i][1];
      bus.req0 = rq_tab[i][0];
      tick();
      chk("rr_gnt1", bus.gnt1, g1_tab[i]);
      chk("rr_gnt0", bus.gnt0, !g1_tab[i]);
      chk("rr_excl", bus.gnt0 & bus.gnt1, 1'b0);
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    tick();
    chk("rr_idle", bus.out_valid, 1'b0);

    // 4: preemption after four cycles, then an unlimited solo hold
    bus.in0  = 1'b1;
    bus.in1  = 1'b0;
    bus.req0 = 1'b1;
    tick();
    chk("pre_gnt0_first", bus.gnt0, 1'b1);
    bus.req1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("pre_gnt0", bus.gnt0, 1'b1);
      chk("pre_out", bus.out, 1'b1);
    end
    tick();
    chk("pre_gnt0_end", bus.gnt0, 1'b0);
    chk("pre_gnt1", bus.gnt1, 1'b1);
    chk("pre_sel", bus.sel, 1'b1);
    bus.req1 = 1'b0;
    tick();
    chk("solo_gnt0_start", bus.gnt0, 1'b1);
    for (int i = 0; i < 22; i++) begin
      tick();
      chk("solo_gnt0", bus.gnt0, 1'b1);
    end

    // 5: handoff with no idle bubble
    bus.in0  = 1'b0;
    bus.in1  = 1'b1;
    bus.req0 = 1'b0;
    bus.req1 = 1'b1;
    tick();
    chk("hand_gnt1", bus.gnt1, 1'b1);
    chk("hand_vld", bus.out_valid, 1'b1);
    chk("hand_out", bus.out, 1'b1);
    tick();
    tick();

    // 6: reset while GRANT1 has cnt=2
    chk("mid_gnt1_before", bus.gnt1, 1'b1);
    reset    = 1'b1;
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    tick();
    chk("mid_gnt1", bus.gnt1, 1'b0);
    chk("mid_sel", bus.sel, 1'b0);
    chk("mid_vld", bus.out_valid, 1'b0);
    chk("mid_h1_vld", bus1.out_valid, 1'b0);
    reset = 1'b0;
    tick();
    chk("mid_rel_gnt0", bus.gnt0, 1'b1);
    chk("h1_rel_gnt0", bus1.gnt0, 1'b1);

    // MAX_HOLD=1 alternates every cycle; MAX_HOLD=4 holds four
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("h1_gnt1", bus1.gnt1, logic'(i % 2));
      chk("h1_out", bus1.out, logic'(i % 2));
      chk("h4_gnt0", bus.gnt0, logic'(i < 4));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
